// File: rtl/mavg_ch_scheduler_if.sv
// Bundle between sample sources, the shared sample RAM and per-channel consumers.
// The scheduler sits on the slave side; the source/RAM/consumer environment is the master.
interface mavg_ch_scheduler_if #(
  parameter int NUM_CH     = 4,
  parameter int WIND_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH-1:0]            ch_flush;
  logic                         ram_we;
  logic [CH_W+WIND_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]        ram_din;
  logic [DATA_WIDTH-1:0]        ram_dout;
  logic [DATA_WIDTH-1:0]        y_data;
  logic [CH_W-1:0]              y_ch;
  logic                         y_valid;

  modport master (
    output req_valid, req_data, ch_flush, ram_dout,
    input  req_ready, ram_we, ram_addr, ram_din, y_data, y_ch, y_valid
  );

  modport slave (
    input  req_valid, req_data, ch_flush, ram_dout,
    output req_ready, ram_we, ram_addr, ram_din, y_data, y_ch, y_valid
  );
endinterface

// File: rtl/mavg_ch_scheduler.sv
// Round-robin scheduler sharing one sample RAM among NUM_CH moving-average channels.
// Issue writes the sample and reads the evicted one; update adjusts the running sum a cycle later.
module mavg_ch_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int WIND_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  mavg_ch_scheduler_if.slave  bus
);
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int MAVG_WIDTH = WIND_WIDTH + DATA_WIDTH;
  localparam int WIND_DEPTH = 2**WIND_WIDTH;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
    logic                  full;
    logic                  last;
  } op_t;

  logic [CH_W-1:0]                   rr_ptr;
  logic [NUM_CH-1:0][WIND_WIDTH-1:0] ptr;
  logic [NUM_CH-1:0]                 fill;
  logic [NUM_CH-1:0][MAVG_WIDTH-1:0] acc;
  logic [NUM_CH-1:0]                 elig, gnt;
  logic                              gnt_any;
  logic [CH_W-1:0]                   gnt_ch;
  logic [DATA_WIDTH-1:0]             gnt_data;
  int                                idx;
  op_t                               s1;
  logic [1:0]                        vld_pipe;
  logic                              upd, emit;
  logic [MAVG_WIDTH-1:0]             acc_next;
  logic [DATA_WIDTH-1:0]             y_data_q;
  logic [CH_W-1:0]                   y_ch_q;

  // A channel being flushed this cycle is never granted.
  assign elig = reset ? '0 : (bus.req_valid & ~bus.ch_flush);

  always_comb begin
    gnt     = '0;
    gnt_ch  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
    if (gnt_any) gnt[gnt_ch] = 1'b1;
  end

  assign gnt_data      = bus.req_data[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
  assign bus.req_ready = gnt;
  assign bus.ram_we    = gnt_any;
  assign bus.ram_addr  = gnt_any ? {gnt_ch, ptr[gnt_ch]} : '0;
  assign bus.ram_din   = gnt_any ? gnt_data : '0;

  // ram_dout is the sample leaving the window; only meaningful once the window has wrapped.
  assign upd      = vld_pipe[0] & ~bus.ch_flush[s1.ch];
  assign emit     = upd & (s1.full | s1.last);
  assign acc_next = acc[s1.ch] + MAVG_WIDTH'(s1.data)
                  - (s1.full ? MAVG_WIDTH'(bus.ram_dout) : '0);

  assign bus.y_valid = vld_pipe[1];
  assign bus.y_data  = y_data_q;
  assign bus.y_ch    = y_ch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      ptr      <= '0;
      fill     <= '0;
      acc      <= '0;
      s1       <= '0;
      vld_pipe <= '0;
      y_data_q <= '0;
      y_ch_q   <= '0;
    end else begin
      s1 <= '{ch: gnt_ch, data: gnt_data, full: fill[gnt_ch],
              last: (ptr[gnt_ch] == WIND_WIDTH'(WIND_DEPTH-1))};
      vld_pipe <= {emit, gnt_any};
      if (gnt_any) begin
        rr_ptr      <= (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + 1'b1;
        ptr[gnt_ch] <= ptr[gnt_ch] + 1'b1;
        if (ptr[gnt_ch] == WIND_WIDTH'(WIND_DEPTH-1)) fill[gnt_ch] <= 1'b1;
      end
      if (upd) acc[s1.ch] <= acc_next;
      if (emit) begin
        y_data_q <= acc_next[MAVG_WIDTH-1:WIND_WIDTH];
        y_ch_q   <= s1.ch;
      end
      // Flush is last so it wins over any same-cycle context update.
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_flush[k]) begin
          ptr[k]  <= '0;
          fill[k] <= 1'b0;
          acc[k]  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mavg_ch_scheduler.sv
// Directed bench for mavg_ch_scheduler (2 channels, window of 4) with a read-first RAM model.
module tb_mavg_ch_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mavg_ch_scheduler_if #(.NUM_CH(2), .WIND_WIDTH(2), .DATA_WIDTH(16)) bus ();
  mavg_ch_scheduler #(.NUM_CH(2), .WIND_WIDTH(2), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Stale contents let the bench see whether unfilled windows mask the read-back.
  logic [15:0] mem [8] = '{default: 16'hDEAD};
  always @(posedge clk) begin
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.ch_flush  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] d);
    bus.req_valid = 2'b01 << ch;
    bus.req_data[ch*16 +: 16] = d;
    #1;
    chk("send_ready", 32'(bus.req_ready), 32'(2'b01 << ch));
    tick();
    bus.req_valid = '0;
  endtask

  task automatic expect_y(input string tag, input logic v, input logic ch, input logic [15:0] y);
    chk(tag, 32'(bus.y_valid), 32'(v));
    if (v) begin
      chk(tag, 32'(bus.y_ch), 32'(ch));
      chk(tag, 32'(bus.y_data), 32'(y));
    end
  endtask

  // 4,8,12,16 on ch0 gives 10; sliding in 20 (evicting 4) gives 14.
  task automatic run_s1();
    bus.req_valid = 2'b01;
    bus.req_data[15:0] = 16'd4;
    #1;
    chk("s1_ready0", 32'(bus.req_ready), 32'h1);
    chk("s1_we0",    32'(bus.ram_we),    32'h1);
    chk("s1_addr0",  32'(bus.ram_addr),  32'h0);
    chk("s1_din0",   32'(bus.ram_din),   32'd4);
    tick();
    bus.req_valid = '0;
    #1;
    chk("s1_idle_we",   32'(bus.ram_we),   32'h0);
    chk("s1_idle_addr", 32'(bus.ram_addr), 32'h0);
    send(0, 16'd8);
    send(0, 16'd12);
    send(0, 16'd16);
    expect_y("s1_early", 1'b0, 1'b0, 16'd0);
    tick();
    expect_y("s1_first", 1'b1, 1'b0, 16'd10);
    tick();
    expect_y("s1_gap", 1'b0, 1'b0, 16'd0);
    chk("s1_hold", 32'(bus.y_data), 32'd10);
    send(0, 16'd20);
    tick();
    expect_y("s1_slide", 1'b1, 1'b0, 16'd14);
  endtask

  initial begin
    logic [15:0] s5_in  [4] = '{16'd1, 16'd1, 16'd1, 16'd2};
    logic [15:0] s5_exp [4] = '{16'hBFFF, 16'h8000, 16'h4000, 16'h0001};
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.ch_flush  = '0;

    do_reset();
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_we",    32'(bus.ram_we),    32'h0);
    expect_y("rst_y", 1'b0, 1'b0, 16'd0);
    chk("rst_ydata", 32'(bus.y_data), 32'h0);
    chk("rst_ych",   32'(bus.y_ch),   32'h0);
    run_s1();

    // Both channels held valid: alternating grants; ch1 flushed at cycle 14 (its cycle-13 op dropped).
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      logic ev;
      logic ech;
      logic [15:0] ey;
      bus.req_valid = 2'b11;
      bus.req_data  = {(i >= 15) ? 16'd40 : 16'd200, 16'd100};
      bus.ch_flush  = (i == 14) ? 2'b10 : 2'b00;
      #1;
      chk("s2_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      ech = 1'(i % 2);
      ey  = ech ? 16'd200 : 16'd100;
      if (i < 8)       ev = 1'b0;
      else if (i <= 14) ev = 1'b1;
      else if (i <= 22) ev = (i % 2 == 0);
      else if (i == 23) begin ev = 1'b1; ey = 16'd40; end
      else             ev = 1'b1;
      expect_y("s23_y", ev, ech, ey);
      tick();
    end
    bus.req_valid = '0;
    bus.ch_flush  = '0;

    // Reset with a ch0 op in flight: strobe is lost and outputs return to zero.
    send(0, 16'd50);
    reset = 1'b1;
    bus.req_valid = 2'b01;
    #1;
    chk("s4_ready_in_rst", 32'(bus.req_ready), 32'h0);
    tick();
    expect_y("s4_after_rst", 1'b0, 1'b0, 16'd0);
    chk("s4_ydata", 32'(bus.y_data), 32'h0);
    chk("s4_ych",   32'(bus.y_ch),   32'h0);
    reset = 1'b0;
    bus.req_valid = '0;
    run_s1();

    // Full-scale window, then sliding small values, then a fresh ch1 window.
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 16'hFFFF);
    tick();
    expect_y("s5_max", 1'b1, 1'b0, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      send(0, s5_in[i]);
      tick();
      expect_y("s5_slide", 1'b1, 1'b0, s5_exp[i]);
    end
    for (int i = 0; i < 4; i++) send(1, s5_in[i]);
    expect_y("s5_ch1_early", 1'b0, 1'b0, 16'd0);
    tick();
    expect_y("s5_ch1", 1'b1, 1'b1, 16'd1);

    // Flush ch0 while it holds priority: ch1 granted, ch0 must refill from scratch.
    bus.req_valid = 2'b11;
    bus.ch_flush  = 2'b01;
    bus.req_data  = {16'd9, 16'd7};
    #1;
    chk("s6_ready", 32'(bus.req_ready), 32'h2);
    chk("s6_addr",  32'(bus.ram_addr),  32'h4);
    tick();
    bus.req_valid = '0;
    bus.ch_flush  = '0;
    tick();
    expect_y("s6_ch1", 1'b1, 1'b1, 16'd3);
    for (int i = 0; i < 4; i++) begin
      send(0, 16'd8);
      expect_y("s6_refill", 1'b0, 1'b0, 16'd0);
    end
    tick();
    expect_y("s6_ch0", 1'b1, 1'b0, 16'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
